// File: rtl/lcd_framebuffer.sv
// Paged monochrome LCD framebuffer: escape-coded byte stream writes pixel bytes at a
// cursor, with a registered random-access read port for the display scan-out.
module lcd_framebuffer #(
  parameter int unsigned WIDTH = 240,
  parameter int unsigned PAGES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [7:0] rd_pixels,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  localparam int unsigned Depth = WIDTH * PAGES;
  localparam int unsigned AW    = $clog2(Depth);

  typedef enum logic [2:0] {StStream, StEsc, StGetX, StGetY, StClear} state_e;

  state_e          state_q, state_d;
  logic [7:0]      x_q, x_d;
  logic [2:0]      page_q, page_d;
  logic [AW-1:0]   clr_q, clr_d;
  logic            ready_q;
  logic            err_q, err_d;
  logic            fd_q, fd_d;
  logic [7:0]      rd_pixels_q;

  logic [7:0]      mem [Depth];

  logic            accept;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;
  logic [AW-1:0]   cur_addr;
  logic            cur_ok;
  logic [7:0]      adv_x;
  logic [2:0]      adv_page;
  logic            adv_wrap;

  logic [2:0]      rd_page;
  logic [AW-1:0]   rd_addr;
  logic            rd_ok;
  logic            unused_rd_y;

  assign unused_rd_y = rd_y[3];

  assign in_ready   = ready_q && (state_q != StClear);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q == StClear);
  assign err        = err_q;
  assign frame_done = fd_q;
  assign rd_pixels  = rd_pixels_q;

  assign cur_addr = AW'(32'(page_q) * WIDTH + 32'(x_q));
  assign cur_ok   = 32'(page_q) < PAGES;

  assign rd_page = rd_y[2:0];
  assign rd_addr = AW'(32'(rd_page) * WIDTH + 32'(rd_x));
  assign rd_ok   = (32'(rd_x) < WIDTH) && (32'(rd_page) < PAGES);

  always_comb begin
    adv_x    = x_q + 8'd1;
    adv_page = page_q;
    adv_wrap = 1'b0;
    if (32'(x_q) == WIDTH - 1) begin
      adv_x = 8'd0;
      if (32'(page_q) == PAGES - 1) begin
        adv_page = 3'd0;
        adv_wrap = 1'b1;
      end else begin
        adv_page = page_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    page_d  = page_q;
    clr_d   = clr_q;
    we      = 1'b0;
    waddr   = cur_addr;
    wdata   = in_data;
    err_d   = 1'b0;
    fd_d    = 1'b0;
    unique case (state_q)
      StStream: begin
        if (accept) begin
          if (in_data == 8'h1B) begin
            state_d = StEsc;
          end else begin
            we     = cur_ok;
            x_d    = adv_x;
            page_d = adv_page;
            fd_d   = adv_wrap;
          end
        end
      end
      StEsc: begin
        if (accept) begin
          case (in_data)
            8'h1B: begin
              we      = cur_ok;
              x_d     = adv_x;
              page_d  = adv_page;
              fd_d    = adv_wrap;
              state_d = StStream;
            end
            8'h50: state_d = StGetX;
            8'h43: begin
              clr_d   = '0;
              state_d = StClear;
            end
            default: begin
              err_d   = 1'b1;
              state_d = StStream;
            end
          endcase
        end
      end
      StGetX: begin
        if (accept) begin
          if (32'(in_data) >= WIDTH) begin
            x_d   = 8'd0;
            err_d = 1'b1;
          end else begin
            x_d = in_data;
          end
          state_d = StGetY;
        end
      end
      StGetY: begin
        if (accept) begin
          page_d  = in_data[2:0];
          state_d = StStream;
        end
      end
      StClear: begin
        we    = 1'b1;
        waddr = clr_q;
        wdata = 8'h00;
        if (clr_q == AW'(Depth - 1)) begin
          clr_d   = '0;
          x_d     = 8'd0;
          page_d  = 3'd0;
          state_d = StStream;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      default: state_d = StStream;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StStream;
      x_q         <= 8'd0;
      page_q      <= 3'd0;
      clr_q       <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      fd_q        <= 1'b0;
      rd_pixels_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      page_q      <= page_d;
      clr_q       <= clr_d;
      ready_q     <= 1'b1;
      err_q       <= err_d;
      fd_q        <= fd_d;
      // Non-blocking read against the same-edge write yields the old byte.
      rd_pixels_q <= rd_ok ? mem[rd_addr] : 8'h00;
    end
  end

  // Storage is deliberately left unreset so a reset mid-clear keeps partial contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_lcd_framebuffer.sv
// Directed bench for lcd_framebuffer; read expectations go through a scoreboard queue
// and are popped when the registered read data appears.
module tb_lcd_framebuffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] rd_x = 8'h00;
  logic [3:0] rd_y = 4'h0;
  logic [7:0] rd_pixels;
  logic       busy;
  logic       frame_done;
  logic       err;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [$];
  logic       last_err;
  logic       last_fd;

  lcd_framebuffer #(.WIDTH(240), .PAGES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_pixels  (rd_pixels),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int x, input int y, input logic [7:0] exp);
    logic [7:0] e;
    @(negedge clk);
    rd_x = 8'(x);
    rd_y = 4'(y);
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("rd(%0d,%0d)", x, y), 32'(rd_pixels), 32'(e));
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    last_err = err;
    last_fd  = frame_done;
  endtask

  initial begin
    int cnt;
    int ready_seen;
    logic [7:0] e;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_pixels", 32'(rd_pixels), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(in_ready), 32'd1);

    // Basic streaming and out-of-range read
    send(8'hAA);
    send(8'h55);
    rd(0, 0, 8'hAA);
    rd(1, 0, 8'h55);
    rd(240, 0, 8'h00);
    rd(255, 3, 8'h00);

    // Cursor positioning and end-of-line advance
    send(8'h1B); send(8'h50); send(8'hEF); send(8'h05);
    send(8'h11);
    check("fd_no_wrap", 32'(last_fd), 32'd0);
    send(8'h22);
    rd(239, 4'b0101, 8'h11);
    rd(0, 4'b0110, 8'h22);
    rd(239, 4'b1101, 8'h11);

    // Frame wrap
    send(8'h1B); send(8'h50); send(8'hEF); send(8'h07);
    send(8'h33);
    check("fd_pulse", 32'(last_fd), 32'd1);
    @(negedge clk);
    check("fd_one_cycle", 32'(frame_done), 32'd0);
    send(8'h44);
    check("fd_after", 32'(last_fd), 32'd0);
    rd(239, 7, 8'h33);
    rd(0, 0, 8'h44);

    // Literal escape, then bad escape
    send(8'h1B); send(8'h1B);
    check("lit_err", 32'(last_err), 32'd0);
    rd(1, 0, 8'h1B);
    send(8'h1B); send(8'h7A);
    check("esc_err", 32'(last_err), 32'd1);
    @(negedge clk);
    check("esc_err_one_cycle", 32'(err), 32'd0);
    send(8'h66);
    rd(2, 0, 8'h66);

    // Read-before-write at the cursor address
    send(8'h1B); send(8'h50); send(8'h02); send(8'h00);
    @(negedge clk);
    rd_x = 8'd2;
    rd_y = 4'd0;
    exp_q.push_back(8'h66);
    in_data  = 8'h88;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    e = exp_q.pop_front();
    check("rbw_old", 32'(rd_pixels), 32'(e));
    rd(2, 0, 8'h88);

    // Clear with in_valid held high throughout
    send(8'h1B);
    send(8'h43);
    in_data  = 8'h99;
    in_valid = 1'b1;
    cnt = 0;
    ready_seen = 0;
    while (busy && cnt < 4000) begin
      cnt++;
      if (in_ready) ready_seen++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("clear_len", 32'(cnt), 32'd1920);
    check("clear_ready_low", 32'(ready_seen), 32'd0);
    for (int p = 0; p < 8; p++) begin
      for (int x = 0; x < 240; x++) begin
        rd(x, p, 8'h00);
      end
    end
    send(8'h12);
    rd(0, 0, 8'h12);

    // GET_X out of range clamps to zero
    send(8'h1B); send(8'h50); send(8'hF5);
    check("getx_err", 32'(last_err), 32'd1);
    send(8'h00);
    send(8'h5A);
    check("getx_no_err", 32'(last_err), 32'd0);
    rd(0, 0, 8'h5A);

    // Reset mid-clear aborts; late addresses keep their contents
    send(8'h1B); send(8'h50); send(8'h64); send(8'h06);
    send(8'hC3);
    rd(100, 6, 8'hC3);
    send(8'h1B);
    send(8'h43);
    check("clear2_busy", 32'(busy), 32'd1);
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready_back", 32'(in_ready), 32'd1);
    check("abort_busy_after", 32'(busy), 32'd0);
    rd(100, 6, 8'hC3);
    send(8'h21);
    rd(0, 0, 8'h21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_framebuffer.md
LCD_FRAMEBUFFER -- requirements
Module: lcd_framebuffer

Interface
REQ-001 SHALL have parameter WIDTH, default 240, meaning pixel columns per page.
REQ-002 SHALL have parameter PAGES, default 8, meaning 8-pixel-high pages (64 rows total).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-low (one clock; reset asynchronous and active-low).
REQ-005 SHALL have port in_data  input  8  command/pixel byte stream.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port rd_x  input  8  display read column, 0..WIDTH-1.
REQ-009 SHALL have port rd_y  input  4  display read row code; page = {rd_y[2], rd_y[1:0]}, rd_y[3] ignored.
REQ-010 SHALL have port rd_pixels  output  8  byte for (rd_x, rd_y), bit 0 = top pixel.
REQ-011 SHALL have port busy  output  1  clear in progress.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse on write-cursor wrap.
REQ-013 SHALL have port err  output  1  one-cycle pulse on protocol error.

Function
REQ-014 SHALL hold WIDTH*PAGES bytes (1920) at address page*WIDTH + x; storage SHALL NOT be reset.
REQ-015 Read port SHALL register rd_pixels exactly 1 cycle after rd_x/rd_y are sampled; rd_x >= WIDTH SHALL return 8'h00.
REQ-016 Same-cycle read and write of one address SHALL return the old data (read-before-write).
REQ-017 A byte SHALL be accepted only on a rising edge with in_valid && in_ready; the RAM write SHALL occur on that same edge.
REQ-018 FSM states: STREAM, ESC, GET_X, GET_Y, CLEAR; state after reset SHALL be STREAM.
REQ-019 STREAM: byte != 8'h1B -> write at cursor, advance cursor; byte == 8'h1B -> ESC, no write.
REQ-020 ESC: 8'h1B -> write literal 8'h1B at cursor, advance, go to STREAM; 8'h50 -> GET_X; 8'h43 -> CLEAR; any other byte -> err pulse, no write, go to STREAM.
REQ-021 GET_X: cursor x <= byte; byte >= WIDTH -> x <= 0 plus err pulse; go to GET_Y.
REQ-022 GET_Y: cursor page <= byte[2:0], upper bits ignored; go to STREAM.
REQ-023 Cursor advance: x+1; at x == WIDTH-1, x <= 0 and page+1; at page PAGES-1 and x WIDTH-1, wrap to (0,0) with a frame_done pulse the following cycle.
REQ-024 CLEAR: write 8'h00 to addresses 0..1919, one per cycle (1920 cycles). Cursor <= (0,0) on exit; then STREAM.
REQ-025 in_ready SHALL be 1 in STREAM, ESC, GET_X and GET_Y, and 0 in CLEAR and during reset.
REQ-026 busy SHALL be 1 for exactly the 1920 CLEAR cycles.
REQ-027 The read port SHALL operate in every state, including CLEAR; rd_pixels reflects the clear progressively.
REQ-028 in_valid held low SHALL leave state and cursor unchanged, in every state including ESC mid-sequence.

Reset
REQ-029 While reset = 0: state STREAM, cursor (0,0), clear counter 0, in_ready 0, busy 0, frame_done 0, err 0, rd_pixels 8'h00.
REQ-030 Reset asserted mid-CLEAR or mid-escape SHALL abort immediately; RAM keeps any partially written contents.
REQ-031 in_ready SHALL rise on the first clock edge after reset deasserts.

Verification
REQ-032 Reset, stream 8'hAA, 8'h55 -> read (x=0,y=0) = 8'hAA, (x=1,y=0) = 8'h55, each 1 cycle after address.
REQ-033 Send 1B 50 EF 05, then 8'h11, 8'h22 -> (239, y=4'b0101) = 8'h11, (0, y=4'b0110) = 8'h22.
REQ-034 Send 1B 50 EF 07, then 8'h33 -> byte lands at (239, page 7), frame_done pulses once, next byte lands at (0,0).
REQ-035 Send 1B 1B -> 8'h1B written at cursor; send 1B 7A -> err pulse, no write, cursor unchanged.
REQ-036 Send 1B 43 -> busy high and in_ready low for 1920 cycles; all 1920 bytes read 8'h00; in_valid held high during CLEAR consumes nothing.
REQ-037 Send 1B 50 F5 -> err pulse, x = 0; reset pulse mid-CLEAR -> busy 0, state STREAM, cursor (0,0).
